decode_stage: RTL and testbench

- Decode stage directly downstream of the fetch stage.
- Consumes the current instruction and its PC from fetch, and steers fetch with fetch_keep/fetch_next.
- Decodes fixed-format 32-bit instructions into a registered valid/ready output bundle for execute.
- Tracks in-flight register writes in a scoreboard to stall on RAW/WAW hazards; halts on a HALT instruction.

---
 rtl/decode_stage.sv | 209 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: takes one fixed-format 32-bit instruction per cycle from fetch,
// checks it against a register scoreboard for RAW/WAW hazards, and issues a
// registered valid/ready bundle to execute. A HALT instruction parks the stage
// until the next reset.
module decode_stage #(
    parameter int INS_SIZE = 32,
    parameter int REG_NUM  = 16,
    parameter int CNT_W    = 16,
    parameter int PC_W     = 16
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic [INS_SIZE-1:0] fetch_inst_i,
    input  logic [PC_W-1:0]     fetch_id_i,
    output logic                fetch_state_o,
    output logic                dec_valid_o,
    input  logic                dec_ready_i,
    output logic [3:0]          dec_op_o,
    output logic [3:0]          dec_rd_o,
    output logic [3:0]          dec_rs1_o,
    output logic [3:0]          dec_rs2_o,
    output logic [15:0]         dec_imm_o,
    output logic                dec_we_o,
    output logic                dec_illegal_o,
    output logic [PC_W-1:0]     dec_id_o,
    input  logic                wb_valid_i,
    input  logic [3:0]          wb_rd_i,
    output logic                halted_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);

    localparam logic FETCH_KEEP = 1'b0;
    localparam logic FETCH_NEXT = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [REG_NUM-1:0]   sb_r;
    logic [REG_NUM-1:0]   sb_next_s;

    logic [3:0]  op_s;
    logic [3:0]  rd_s;
    logic [3:0]  rs1_s;
    logic [3:0]  rs2_s;
    logic [15:0] imm_s;
    logic        use_rs1_s;
    logic        use_rs2_s;
    logic        writes_s;
    logic        we_s;
    logic        illegal_s;
    logic        is_halt_s;
    logic        hazard_s;
    logic        active_s;
    logic        accept_s;

    assign op_s  = fetch_inst_i[31:28];
    assign rd_s  = fetch_inst_i[27:24];
    assign rs1_s = fetch_inst_i[23:20];
    assign rs2_s = fetch_inst_i[19:16];
    assign imm_s = fetch_inst_i[15:0];

    // Opcode classification: which sources are read, whether rd is written.
    always_comb begin
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        writes_s  = 1'b0;
        illegal_s = 1'b0;
        is_halt_s = 1'b0;
        case (op_s)
            4'd0: begin
            end
            4'd1, 4'd2, 4'd3, 4'd4: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                writes_s  = 1'b1;
            end
            4'd5: begin
                use_rs1_s = 1'b1;
                writes_s  = 1'b1;
            end
            4'd6: begin
                writes_s = 1'b1;
            end
            4'd15: begin
                is_halt_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Register 0 is never a real destination, so it never writes or blocks.
    assign we_s = writes_s && (rd_s != 4'd0);

    // Hazard against the scoreboard as it stands this cycle (no wb bypass).
    assign hazard_s = (use_rs1_s && sb_r[rs1_s]) ||
                      (use_rs2_s && sb_r[rs2_s]) ||
                      (we_s && sb_r[rd_s]);

    assign active_s = (state_r == ST_RUN) || (state_r == ST_STALL);
    assign accept_s = active_s && !hazard_s && (!dec_valid_o || dec_ready_i);

    // Fetch steering; forced to keep while reset is held.
    always_comb begin
        if (arstn && accept_s) begin
            fetch_state_o = FETCH_NEXT;
        end else begin
            fetch_state_o = FETCH_KEEP;
        end
    end

    // FSM next state; a blocked slot without a hazard leaves the state alone.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN, ST_STALL: begin
                if (hazard_s) begin
                    state_next_s = ST_STALL;
                end else if (accept_s) begin
                    state_next_s = is_halt_s ? ST_HALTED : ST_RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_HALTED: begin
                state_next_s = ST_HALTED;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Scoreboard update: clear on writeback first, then set on issue so set wins.
    always_comb begin
        sb_next_s = sb_r;
        if (wb_valid_i) begin
            sb_next_s[wb_rd_i] = 1'b0;
        end else begin
            sb_next_s = sb_r;
        end
        if (accept_s && we_s) begin
            sb_next_s[rd_s] = 1'b1;
        end else begin
            sb_next_s[0] = sb_next_s[0];
        end
        sb_next_s[0] = 1'b0;
    end

    // FSM state, halt flag and scoreboard registers.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_r  <= ST_RUN;
            halted_o <= 1'b0;
            sb_r     <= {REG_NUM{1'b0}};
        end else begin
            state_r  <= state_next_s;
            halted_o <= (state_next_s == ST_HALTED);
            sb_r     <= sb_next_s;
        end
    end

    // Output bundle: load on accept, drop valid once execute has taken it.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            dec_valid_o   <= 1'b0;
            dec_op_o      <= 4'd0;
            dec_rd_o      <= 4'd0;
            dec_rs1_o     <= 4'd0;
            dec_rs2_o     <= 4'd0;
            dec_imm_o     <= 16'd0;
            dec_we_o      <= 1'b0;
            dec_illegal_o <= 1'b0;
            dec_id_o      <= {PC_W{1'b0}};
        end else if (accept_s) begin
            dec_valid_o   <= 1'b1;
            dec_op_o      <= op_s;
            dec_rd_o      <= rd_s;
            dec_rs1_o     <= rs1_s;
            dec_rs2_o     <= rs2_s;
            dec_imm_o     <= imm_s;
            dec_we_o      <= we_s;
            dec_illegal_o <= illegal_s;
            dec_id_o      <= fetch_id_i;
        end else if (dec_valid_o && dec_ready_i) begin
            dec_valid_o   <= 1'b0;
        end else begin
            dec_valid_o   <= dec_valid_o;
        end
    end

    // Saturating count of cycles spent in STALL.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            stall_cnt_o <= {CNT_W{1'b0}};
        end else if ((state_r == ST_STALL) && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_o <= stall_cnt_o;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: small instruction ROM indexed by a bench-side
// fetch PC that advances whenever the stage signals fetch_next.
module tb_decode_stage;

    logic        clk;
    logic        arstn;
    logic [31:0] fetch_inst;
    logic [15:0] fetch_id;
    logic        fetch_state;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_op;
    logic [3:0]  dec_rd;
    logic [3:0]  dec_rs1;
    logic [3:0]  dec_rs2;
    logic [15:0] dec_imm;
    logic        dec_we;
    logic        dec_illegal;
    logic [15:0] dec_id;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        halted;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    int pc    = 0;

    decode_stage dut (
        .clk           (clk),
        .arstn         (arstn),
        .fetch_inst_i  (fetch_inst),
        .fetch_id_i    (fetch_id),
        .fetch_state_o (fetch_state),
        .dec_valid_o   (dec_valid),
        .dec_ready_i   (dec_ready),
        .dec_op_o      (dec_op),
        .dec_rd_o      (dec_rd),
        .dec_rs1_o     (dec_rs1),
        .dec_rs2_o     (dec_rs2),
        .dec_imm_o     (dec_imm),
        .dec_we_o      (dec_we),
        .dec_illegal_o (dec_illegal),
        .dec_id_o      (dec_id),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .halted_o      (halted),
        .stall_cnt_o   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input int a);
        case (a)
            0: rom = 32'h6100_0005; // LOADI r1,0x0005
            1: rom = 32'h6200_0003; // LOADI r2,0x0003
            2: rom = 32'h1312_0000; // ADD r3,r1,r2
            3: rom = 32'h0000_0000; // NOP
            4: rom = 32'h9500_0000; // illegal opcode 9, rd 5
            5: rom = 32'h6000_1234; // LOADI r0,0x1234
            6: rom = 32'h1400_0000; // ADD r4,r0,r0
            7: rom = 32'hF000_0000; // HALT
            default: rom = 32'h0000_0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_bundle(input string tag, input logic [3:0] op, input logic [3:0] rd,
                              input logic [15:0] id, input logic we, input logic ill);
        chk({tag, ".valid"}, {31'd0, dec_valid}, 32'd1);
        chk({tag, ".op"}, {28'd0, dec_op}, {28'd0, op});
        chk({tag, ".rd"}, {28'd0, dec_rd}, {28'd0, rd});
        chk({tag, ".id"}, {16'd0, dec_id}, {16'd0, id});
        chk({tag, ".we"}, {31'd0, dec_we}, {31'd0, we});
        chk({tag, ".ill"}, {31'd0, dec_illegal}, {31'd0, ill});
    endtask

    task automatic present();
        fetch_inst = rom(pc);
        fetch_id   = pc[15:0];
    endtask

    // One clock: note the fetch decision before the edge, advance the PC after it.
    task automatic tick();
        logic adv;
        @(negedge clk);
        adv = fetch_state;
        @(posedge clk);
        #1;
        if (adv) pc++;
        present();
    endtask

    initial begin
        arstn     = 1'b0;
        dec_ready = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = 4'd0;
        pc        = 0;
        present();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid", {31'd0, dec_valid}, 32'd0);
        chk("rst.fetch", {31'd0, fetch_state}, 32'd0);
        chk("rst.halted", {31'd0, halted}, 32'd0);
        chk("rst.cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst.id", {16'd0, dec_id}, 32'd0);

        arstn     = 1'b1;
        dec_ready = 1'b1;

        tick();
        chk_bundle("ld1", 4'd6, 4'd1, 16'd0, 1'b1, 1'b0);
        chk("ld1.imm", {16'd0, dec_imm}, 32'h0005);
        tick();
        chk_bundle("ld2", 4'd6, 4'd2, 16'd1, 1'b1, 1'b0);

        // ADD r3,r1,r2 now sees r1 and r2 busy
        tick();
        chk("stall.valid", {31'd0, dec_valid}, 32'd0);
        chk("stall.fetch", {31'd0, fetch_state}, 32'd0);
        chk("stall.cnt0", {16'd0, stall_cnt}, 32'd0);
        chk("stall.pc", pc, 32'd2);

        wb_valid = 1'b1;
        wb_rd    = 4'd1;
        tick();
        chk("wb1.cnt", {16'd0, stall_cnt}, 32'd1);
        chk("wb1.fetch", {31'd0, fetch_state}, 32'd0);
        wb_rd    = 4'd2;
        tick();
        wb_valid = 1'b0;
        chk("wb2.cnt", {16'd0, stall_cnt}, 32'd2);
        chk("wb2.fetch", {31'd0, fetch_state}, 32'd1);
        tick();
        chk_bundle("add", 4'd1, 4'd3, 16'd2, 1'b1, 1'b0);
        chk("add.rs1", {28'd0, dec_rs1}, 32'd1);
        chk("add.rs2", {28'd0, dec_rs2}, 32'd2);
        chk("add.cnt", {16'd0, stall_cnt}, 32'd3);

        tick();
        chk_bundle("nop", 4'd0, 4'd0, 16'd3, 1'b0, 1'b0);
        dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_bundle("bp", 4'd0, 4'd0, 16'd3, 1'b0, 1'b0);
            chk("bp.fetch", {31'd0, fetch_state}, 32'd0);
            chk("bp.cnt", {16'd0, stall_cnt}, 32'd3);
        end
        dec_ready = 1'b1;
        tick();
        chk_bundle("ill", 4'd9, 4'd5, 16'd4, 1'b0, 1'b1);

        tick();
        chk_bundle("ldr0", 4'd6, 4'd0, 16'd5, 1'b0, 1'b0);
        chk("ldr0.imm", {16'd0, dec_imm}, 32'h1234);
        tick();
        chk_bundle("addr0", 4'd1, 4'd4, 16'd6, 1'b1, 1'b0);
        chk("addr0.cnt", {16'd0, stall_cnt}, 32'd3);

        tick();
        chk_bundle("halt", 4'd15, 4'd0, 16'd7, 1'b0, 1'b0);
        chk("halt.halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hlt.fetch", {31'd0, fetch_state}, 32'd0);
            chk("hlt.halted", {31'd0, halted}, 32'd1);
        end
        chk("hlt.valid", {31'd0, dec_valid}, 32'd0);
        chk("hlt.pc", pc, 32'd8);

        // Reset in the middle of the run
        arstn = 1'b0;
        #2;
        chk("mrst.valid", {31'd0, dec_valid}, 32'd0);
        chk("mrst.halted", {31'd0, halted}, 32'd0);
        chk("mrst.fetch", {31'd0, fetch_state}, 32'd0);
        chk("mrst.cnt", {16'd0, stall_cnt}, 32'd0);
        chk("mrst.op", {28'd0, dec_op}, 32'd0);
        chk("mrst.id", {16'd0, dec_id}, 32'd0);
        @(posedge clk);
        #1;
        arstn = 1'b1;
        pc    = 0;
        present();
        tick();
        chk_bundle("restart", 4'd6, 4'd1, 16'd0, 1'b1, 1'b0);
        chk("restart.halted", {31'd0, halted}, 32'd0);
        tick();
        chk_bundle("restart2", 4'd6, 4'd2, 16'd1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
